// File: rtl/rsa_word_loader_pkg.sv
// Shared RSA definitions: field widths, the RSAModIn record and the loader state encoding.
package rsa_word_loader_pkg;

  localparam int MOD_WIDTH     = 256;
  localparam int WORD_WIDTH    = 32;
  localparam int WORDS_PER_KEY = MOD_WIDTH / WORD_WIDTH;
  localparam int CNT_W         = $clog2(WORDS_PER_KEY);

  typedef logic [WORD_WIDTH-1:0] WordType;
  typedef logic [MOD_WIDTH-1:0]  KeyType;

  typedef struct packed {
    KeyType msg;
    KeyType key;
    KeyType modulus;
  } RSAModIn;

  // Legacy-compatible state encoding of LoaderState
  typedef logic [1:0] LoaderState;
  localparam LoaderState S_MSG = 2'd0;
  localparam LoaderState S_KEY = 2'd1;
  localparam LoaderState S_MOD = 2'd2;
  localparam LoaderState S_OUT = 2'd3;

endpackage

// File: rtl/rsa_word_loader_if.sv
// Word-stream input and record-output handshakes of the RSA word loader.
interface rsa_word_loader_if;
  import rsa_word_loader_pkg::*;

  logic    i_valid;
  logic    i_ready;
  WordType i_word;
  logic    i_last;
  logic    o_valid;
  logic    o_ready;
  RSAModIn o_out;
  logic    o_err;

  modport master (
    output i_valid, i_word, i_last, o_ready,
    input  i_ready, o_valid, o_out, o_err
  );

  modport slave (
    input  i_valid, i_word, i_last, o_ready,
    output i_ready, o_valid, o_out, o_err
  );

endinterface

// File: rtl/rsa_word_loader_counter.sv
// Word index within a field; wrap flags the transfer of the last word of a field.
module rsa_word_counter
  import rsa_word_loader_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] MAX_COUNT = CNT_W'(WORDS_PER_KEY - 1);

  assign wrap = en && (count == MAX_COUNT);

  // Clear wins over enable so a discarded word never advances the index
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (wrap) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/rsa_word_loader.sv
// Deserialises a framed 32-bit word stream into one RSAModIn record and holds it
// until the RSA top accepts it; malformed frames are dropped with an o_err pulse.
module rsa_word_loader
  import rsa_word_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  rsa_word_loader_if.slave   bus
);

  LoaderState       state;
  RSAModIn          rec;
  logic [CNT_W-1:0] cnt;
  logic             wrap;
  logic             loading;
  logic             xfer;
  logic             last_word;
  logic             frame_err;
  logic             err_q;

  // Ready and valid come straight from the state register, so there is no
  // combinational path between the two handshakes.
  assign loading     = (state != S_OUT);
  assign xfer        = bus.i_valid && loading;
  assign last_word   = (state == S_MOD) && (cnt == CNT_W'(WORDS_PER_KEY - 1));
  assign frame_err   = xfer && (bus.i_last != last_word);

  assign bus.i_ready = loading;
  assign bus.o_valid = (state == S_OUT);
  assign bus.o_out   = rec;
  assign bus.o_err   = err_q;

  rsa_word_counter u_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (frame_err || ((state == S_OUT) && bus.o_ready)),
    .en    (xfer),
    .count (cnt),
    .wrap  (wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_MSG;
      rec   <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= frame_err;
      case (state)
        S_MSG, S_KEY, S_MOD: begin
          if (xfer) begin
            case (state)
              S_MSG:   rec.msg[cnt*WORD_WIDTH +: WORD_WIDTH]     <= bus.i_word;
              S_KEY:   rec.key[cnt*WORD_WIDTH +: WORD_WIDTH]     <= bus.i_word;
              default: rec.modulus[cnt*WORD_WIDTH +: WORD_WIDTH] <= bus.i_word;
            endcase
            if (frame_err) begin
              state <= S_MSG;
            end else if (wrap) begin
              state <= (state == S_MSG) ? S_KEY :
                       (state == S_KEY) ? S_MOD : S_OUT;
            end
          end
        end
        S_OUT: begin
          if (bus.o_ready) begin
            state <= S_MSG;
          end
        end
        default: state <= S_MSG;
      endcase
    end
  end

endmodule
